// File: rtl/mac4x4_acc.sv
// Streaming signed 4x4 multiply-accumulate with saturating sum and one result per frame.
// Operand pairs arrive on a valid/ready handshake; each frame's dot product leaves on a second one.

module mult4x4 (
    input  logic signed [3:0] a,
    input  logic signed [3:0] b,
    output logic signed [7:0] p
);
    // Operands are sign-extended to 8 bits before multiplying, so (-8)*(-8) yields +64.
    assign p = 8'(a) * 8'(b);
endmodule

module mac4x4_acc #(
    parameter int unsigned N_TERMS   = 8,
    parameter int unsigned ACC_WIDTH = 12
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [3:0]           in_a,
    input  logic signed [3:0]           in_b,
    input  logic                        in_last,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [ACC_WIDTH-1:0] out_sum,
    output logic [7:0]                  out_count,
    output logic                        out_ovf
);
    localparam int unsigned SW = ACC_WIDTH + 1;

    typedef enum logic {ACCUM, DONE} state_t;

    state_t                 state_q, state_d;
    logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [7:0]             cnt_q, cnt_d;
    logic                   ovf_q, ovf_d;
    logic                   out_valid_d;
    logic signed [ACC_WIDTH-1:0] out_sum_d;
    logic [7:0]             out_count_d;
    logic                   out_ovf_d;

    logic signed [7:0]      prod;
    logic signed [SW-1:0]   sum_wide;
    logic signed [ACC_WIDTH-1:0] acc_sat;
    logic                   sat_hit;
    logic [7:0]             cnt_inc;

    mult4x4 u_mult (
        .a (in_a),
        .b (in_b),
        .p (prod)
    );

    // One guard bit is enough: |product| <= 64 and ACC_WIDTH >= 8.
    always_comb begin
        sum_wide = SW'(acc_q) + SW'(prod);
        sat_hit  = sum_wide[SW-1] != sum_wide[SW-2];
        if (!sat_hit) begin
            acc_sat = sum_wide[ACC_WIDTH-1:0];
        end else if (sum_wide[SW-1]) begin
            acc_sat = {1'b1, {(ACC_WIDTH-1){1'b0}}};
        end else begin
            acc_sat = {1'b0, {(ACC_WIDTH-1){1'b1}}};
        end
        cnt_inc = cnt_q + 8'd1;
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid;
        out_sum_d   = out_sum;
        out_count_d = out_count;
        out_ovf_d   = out_ovf;
        in_ready    = 1'b0;
        case (state_q)
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    acc_d = acc_sat;
                    cnt_d = cnt_inc;
                    ovf_d = ovf_q | sat_hit;
                    if (in_last || (cnt_q == 8'(N_TERMS - 1))) begin
                        state_d     = DONE;
                        out_valid_d = 1'b1;
                        out_sum_d   = acc_sat;
                        out_count_d = cnt_inc;
                        out_ovf_d   = ovf_q | sat_hit;
                    end
                end
            end
            DONE: begin
                // Result held until consumed; the frame state clears on the handshake.
                if (out_ready) begin
                    state_d     = ACCUM;
                    out_valid_d = 1'b0;
                    acc_d       = '0;
                    cnt_d       = '0;
                    ovf_d       = 1'b0;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ACCUM;
            acc_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_count <= '0;
            out_ovf   <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            out_valid <= out_valid_d;
            out_sum   <= out_sum_d;
            out_count <= out_count_d;
            out_ovf   <= out_ovf_d;
        end
    end
endmodule
